// File: rtl/start_screen_draw_pkg.sv
// Shared types and constants for the start-screen overlay: FSM encoding,
// VGA field widths, default image geometry and the ROM address helper.
package start_screen_draw_pkg;
  localparam int CNT_W  = 11;
  localparam int RGB_W  = 12;
  localparam int ADDR_W = 19;

  localparam int X0_DEF    = 200;
  localparam int Y0_DEF    = 150;
  localparam int IMG_W_DEF = 400;
  localparam int IMG_H_DEF = 300;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } timing_t;

  // Row-major image address from window-relative coordinates.
  function automatic logic [ADDR_W-1:0] img_addr(input logic [CNT_W-1:0] dx,
                                                 input logic [CNT_W-1:0] dy,
                                                 input int stride);
    img_addr = ADDR_W'(dy) * ADDR_W'(stride) + ADDR_W'(dx);
  endfunction
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; rise is high for
// one clock per low-to-high transition of the synchronized input.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/start_screen_draw.sv
// Start-screen overlay in the VGA pipeline: addresses the image ROM, shows the
// grey image until play begins, then passes the game picture with 2-cycle delay.
module start_screen_draw
  import start_screen_draw_pkg::*;
#(
  parameter int X0    = X0_DEF,
  parameter int Y0    = Y0_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic              start_btn,
  input  logic              restart,
  output logic [18:0]       rom_addr,
  input  logic [3:0]        rom_rgb,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic              screen_active,
  output logic              game_start
);
  localparam logic [CNT_W-1:0] X_LO = CNT_W'(X0);
  localparam logic [CNT_W-1:0] X_HI = CNT_W'(X0 + IMG_W);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y0);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y0 + IMG_H);

  state_e            state_q, state_d;
  timing_t           tim_in, s1_q, s1_d, s2_q, s2_d;
  logic [RGB_W-1:0]  rgb1_q, rgb1_d, rgb_out_q, rgb_out_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              win1_q, win1_d;
  logic              game_start_q, game_start_d;
  logic              screen_active_q, screen_active_d;
  logic              in_win, frame_start, btn_rise;

  sync_edge u_start_sync (
    .clk  (pclk),
    .rst  (rst),
    .d_in (start_btn),
    .rise (btn_rise)
  );

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
  assign frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign in_win = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                  (vcount_in >= Y_LO) && (vcount_in < Y_HI) &&
                  !hblnk_in && !vblnk_in;

  always_comb begin
    state_d      = state_q;
    game_start_d = 1'b0;
    // Leaving ARMED/PLAY only on the frame-start pixel keeps every frame whole.
    case (state_q)
      SHOW:    if (btn_rise) state_d = ARMED;
      ARMED:   if (frame_start) begin
                 state_d      = PLAY;
                 game_start_d = 1'b1;
               end
      PLAY:    if (frame_start && restart) state_d = SHOW;
      default: state_d = SHOW;
    endcase
    screen_active_d = (state_d != PLAY);

    s1_d       = tim_in;
    rgb1_d     = rgb_in;
    win1_d     = in_win;
    rom_addr_d = in_win ? img_addr(hcount_in - X_LO, vcount_in - Y_LO, IMG_W)
                        : rom_addr_q;

    // state_q here is already the mode of the stage-1 pixel, since any change
    // happened on the same edge that captured the frame-start pixel.
    s2_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) rgb_out_d = '0;
    else if (state_q == PLAY)     rgb_out_d = rgb1_q;
    else if (win1_q)              rgb_out_d = {rom_rgb, rom_rgb, rom_rgb};
    else                          rgb_out_d = '0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q         <= SHOW;
      game_start_q    <= 1'b0;
      screen_active_q <= 1'b1;
      s1_q            <= '0;
      rgb1_q          <= '0;
      win1_q          <= 1'b0;
      rom_addr_q      <= '0;
      s2_q            <= '0;
      rgb_out_q       <= '0;
    end else begin
      state_q         <= state_d;
      game_start_q    <= game_start_d;
      screen_active_q <= screen_active_d;
      s1_q            <= s1_d;
      rgb1_q          <= rgb1_d;
      win1_q          <= win1_d;
      rom_addr_q      <= rom_addr_d;
      s2_q            <= s2_d;
      rgb_out_q       <= rgb_out_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign hcount_out    = s2_q.hcount;
  assign vcount_out    = s2_q.vcount;
  assign hsync_out     = s2_q.hsync;
  assign vsync_out     = s2_q.vsync;
  assign hblnk_out     = s2_q.hblnk;
  assign vblnk_out     = s2_q.vblnk;
  assign rgb_out       = rgb_out_q;
  assign screen_active = screen_active_q;
  assign game_start    = game_start_q;
endmodule

// File: tb/tb_start_screen_draw.sv
// Directed bench for start_screen_draw: per-pixel vectors with hand-chosen
// expected mode, checked against delayed timing and an expected-colour queue.
module tb_start_screen_draw;
  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        start_btn = 1'b0, restart = 1'b0;
  logic [18:0] rom_addr;
  logic [3:0]  rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        screen_active, game_start;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } tim_t;

  tim_t        prev;
  logic [11:0] exp_q[$];
  logic [18:0] last_addr;
  logic [11:0] rgb_drv = 12'h000;
  int          n_checks = 0;
  int          n_fail = 0;

  start_screen_draw dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_btn(start_btn), .restart(restart),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .screen_active(screen_active), .game_start(game_start)
  );

  always #5 pclk = ~pclk;

  // ROM model: combinational, address 0 returns 4'hA.
  assign rom_rgb = rom_addr[3:0] ^ 4'hA;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_screen_active", 32'(screen_active), 32'd1);
    check_eq("rst_game_start", 32'(game_start), 32'd0);
    check_eq("rst_rgb_out", 32'(rgb_out), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_hcount_out", 32'(hcount_out), 32'd0);
    check_eq("rst_vcount_out", 32'(vcount_out), 32'd0);
    @(posedge pclk);
    #1;
    rst = 1'b0;
    prev = '0;
    exp_q.delete();
    exp_q.push_back(12'h000);
    last_addr = '0;
  endtask

  // One pixel: drive it, clock once, check outputs for the previous pixel.
  // play = expected mode of this pixel, gs = expected game_start after this edge.
  task automatic step(input int h, input int v, input logic play, input logic gs);
    tim_t        cur;
    logic        win;
    logic [18:0] addr;
    logic [3:0]  c;
    logic [11:0] er;
    cur.h  = 11'(h);
    cur.v  = 11'(v);
    cur.hb = (h >= 800);
    cur.vb = (v >= 600);
    cur.hs = (h >= 840) && (h < 968);
    cur.vs = (v >= 601) && (v < 605);
    win    = (h >= 200) && (h < 600) && (v >= 150) && (v < 450) && !cur.hb && !cur.vb;
    addr   = 19'((v - 150) * 400 + (h - 200));
    hcount_in = cur.h;
    vcount_in = cur.v;
    hsync_in  = cur.hs;
    vsync_in  = cur.vs;
    hblnk_in  = cur.hb;
    vblnk_in  = cur.vb;
    rgb_in    = rgb_drv;
    @(posedge pclk);
    #1;
    check_eq("hcount_out", 32'(hcount_out), 32'(prev.h));
    check_eq("vcount_out", 32'(vcount_out), 32'(prev.v));
    check_eq("hsync_out", 32'(hsync_out), 32'(prev.hs));
    check_eq("vsync_out", 32'(vsync_out), 32'(prev.vs));
    check_eq("hblnk_out", 32'(hblnk_out), 32'(prev.hb));
    check_eq("vblnk_out", 32'(vblnk_out), 32'(prev.vb));
    if (exp_q.size() == 0) check_eq("rgb_queue_empty", 32'(exp_q.size()), 32'd1);
    else check_eq("rgb_out", 32'(rgb_out), 32'(exp_q.pop_front()));
    check_eq("screen_active", 32'(screen_active), 32'(!play));
    check_eq("game_start", 32'(game_start), 32'(gs));
    if (win) last_addr = addr;
    check_eq("rom_addr", 32'(rom_addr), 32'(last_addr));
    c = last_addr[3:0] ^ 4'hA;
    if (cur.hb || cur.vb) er = 12'h000;
    else if (play)        er = rgb_drv;
    else if (win)         er = {c, c, c};
    else                  er = 12'h000;
    exp_q.push_back(er);
    prev = cur;
  endtask

  initial begin
    #1;
    do_reset();

    // Free-running pixels across the window's top-left corner, then reset mid-frame.
    for (int h = 196; h < 204; h++) step(h, 150, 1'b0, 1'b0);
    do_reset();
    for (int h = 204; h < 210; h++) step(h, 150, 1'b0, 1'b0);

    // SHOW: window corners, outside pixels and blanking against a loud rgb_in.
    rgb_drv = 12'hF0F;
    step(199, 150, 1'b0, 1'b0);
    step(200, 150, 1'b0, 1'b0);
    step(201, 150, 1'b0, 1'b0);
    step(599, 449, 1'b0, 1'b0);
    step(600, 449, 1'b0, 1'b0);
    step(100, 300, 1'b0, 1'b0);
    step(850, 200, 1'b0, 1'b0);
    step(300, 620, 1'b0, 1'b0);
    step(300, 300, 1'b0, 1'b0);
    step(599, 150, 1'b0, 1'b0);
    step(200, 449, 1'b0, 1'b0);

    // Start pressed mid-frame: play begins only at the next frame start.
    rgb_drv = 12'h3C5;
    start_btn = 1'b1;
    step(300, 300, 1'b0, 1'b0);
    step(301, 300, 1'b0, 1'b0);
    start_btn = 1'b0;
    for (int h = 302; h < 306; h++) step(h, 300, 1'b0, 1'b0);
    step(850, 599, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1);
    step(1, 0, 1'b1, 1'b0);
    step(300, 300, 1'b1, 1'b0);
    // A new press during PLAY changes nothing.
    start_btn = 1'b1;
    step(301, 300, 1'b1, 1'b0);
    step(302, 300, 1'b1, 1'b0);
    start_btn = 1'b0;
    step(303, 300, 1'b1, 1'b0);
    step(900, 300, 1'b1, 1'b0);
    step(304, 300, 1'b1, 1'b0);

    // Restart mid-frame: image returns from the next frame start.
    restart = 1'b1;
    step(305, 300, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    restart = 1'b0;
    step(200, 150, 1'b0, 1'b0);
    step(201, 150, 1'b0, 1'b0);
    step(1000, 700, 1'b0, 1'b0);

    // Restart while in SHOW is ignored, even across a frame start.
    restart = 1'b1;
    step(250, 200, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(250, 200, 1'b0, 1'b0);
    restart = 1'b0;

    // Press lands on the frame-start pixel: armed there, play a frame later.
    start_btn = 1'b1;
    step(500, 599, 1'b0, 1'b0);
    step(700, 599, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(300, 300, 1'b0, 1'b0);
    step(301, 300, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1);
    step(300, 300, 1'b1, 1'b0);
    // Button still held through restart: no re-arm.
    restart = 1'b1;
    step(301, 300, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    restart = 1'b0;
    step(300, 300, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(302, 300, 1'b0, 1'b0);
    start_btn = 1'b0;
    step(303, 300, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(304, 300, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
